// File: rtl/pipe_pkg.sv
// Shared definitions for the LEGv8 pipeline control blocks: register index
// geometry and the encoding of the ALU-operand forwarding mux selects.
package pipe_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int ZERO_REG   = 31;

    // Operand mux select encoding; 2'd3 is never driven.
    localparam logic [1:0] FWD_RF    = 2'd0;
    localparam logic [1:0] FWD_MEMWB = 2'd1;
    localparam logic [1:0] FWD_EXMEM = 2'd2;

endpackage

// File: rtl/fwd_sel_unit.sv
// Forwarding select for one ALU operand. Compares the EX source register
// against the producers sitting in MEM and WB; the younger (MEM) producer wins.
// Purely combinational from registered pipeline state.
module fwd_sel_unit #(
    parameter int REG_ADDR_W = pipe_pkg::REG_ADDR_W,
    parameter int ZERO_REG   = pipe_pkg::ZERO_REG
) (
    input  logic                  ex_valid,
    input  logic                  ex_use,
    input  logic [REG_ADDR_W-1:0] ex_src,
    input  logic                  mem_valid,
    input  logic                  mem_reg_write,
    input  logic [REG_ADDR_W-1:0] mem_rd,
    input  logic                  wb_valid,
    input  logic                  wb_reg_write,
    input  logic [REG_ADDR_W-1:0] wb_rd,
    output logic [1:0]            sel
);
    import pipe_pkg::*;

    localparam logic [REG_ADDR_W-1:0] ZERO_IDX = REG_ADDR_W'(ZERO_REG);

    logic mem_hit;
    logic wb_hit;

    // A producer matches only if it really writes a non-XZR register.
    assign mem_hit = mem_valid && mem_reg_write && (mem_rd != ZERO_IDX) && (mem_rd == ex_src);
    assign wb_hit  = wb_valid  && wb_reg_write  && (wb_rd  != ZERO_IDX) && (wb_rd  == ex_src);

    // Priority select: EX/MEM result before MEM/WB result before register file.
    always_comb begin
        sel = FWD_RF;
        if (ex_valid && ex_use) begin
            if (mem_hit) begin
                sel = FWD_EXMEM;
            end else if (wb_hit) begin
                sel = FWD_MEMWB;
            end
        end
    end

endmodule

// File: rtl/fwd_hazard_ctrl.sv
// Forwarding and load-use hazard controller for the 5-stage LEGv8 pipeline.
// Holds a shadow copy of the EX/MEM/WB control fields that advances in
// lockstep with the datapath. The only "handshake" is stall: when high, the
// pipeline front end must hold PC and IF/ID so the same ID instruction is
// presented again next cycle, while a bubble enters EX. flush overrides stall
// and drops the ID instruction instead.
module fwd_hazard_ctrl #(
    parameter int REG_ADDR_W = pipe_pkg::REG_ADDR_W,
    parameter int ZERO_REG   = pipe_pkg::ZERO_REG,
    parameter int CNT_W      = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_rn,
    input  logic [REG_ADDR_W-1:0] id_rm,
    input  logic                  id_use_rn,
    input  logic                  id_use_rm,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic                  id_reg_write,
    input  logic                  id_mem_read,
    input  logic                  flush,
    output logic [1:0]            fwd_a_sel,
    output logic [1:0]            fwd_b_sel,
    output logic                  stall,
    output logic                  ex_valid,
    output logic [CNT_W-1:0]      stall_count
);
    import pipe_pkg::*;

    localparam logic [REG_ADDR_W-1:0] ZERO_IDX = REG_ADDR_W'(ZERO_REG);

    logic [REG_ADDR_W-1:0] ex_rn;
    logic [REG_ADDR_W-1:0] ex_rm;
    logic                  ex_use_rn;
    logic                  ex_use_rm;
    logic [REG_ADDR_W-1:0] ex_rd;
    logic                  ex_reg_write;
    logic                  ex_mem_read;

    logic                  mem_valid;
    logic [REG_ADDR_W-1:0] mem_rd;
    logic                  mem_reg_write;

    logic                  wb_valid;
    logic [REG_ADDR_W-1:0] wb_rd;
    logic                  wb_reg_write;

    logic                  load_use;

    // A load in EX whose destination is read by the ID instruction cannot be
    // forwarded in time; one bubble moves the load to MEM so the consumer
    // later picks the value up from WB.
    assign load_use = id_valid && ex_valid && ex_mem_read && ex_reg_write &&
                      (ex_rd != ZERO_IDX) &&
                      ((id_use_rn && (id_rn == ex_rd)) || (id_use_rm && (id_rm == ex_rd)));
    assign stall    = !flush && load_use;

    // Shadow pipeline: MEM and WB always advance; EX takes ID, a bubble, or a flush.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid      <= 1'b0;
            ex_rn         <= '0;
            ex_rm         <= '0;
            ex_use_rn     <= 1'b0;
            ex_use_rm     <= 1'b0;
            ex_rd         <= '0;
            ex_reg_write  <= 1'b0;
            ex_mem_read   <= 1'b0;
            mem_valid     <= 1'b0;
            mem_rd        <= '0;
            mem_reg_write <= 1'b0;
            wb_valid      <= 1'b0;
            wb_rd         <= '0;
            wb_reg_write  <= 1'b0;
        end else begin
            wb_valid      <= mem_valid;
            wb_rd         <= mem_rd;
            wb_reg_write  <= mem_reg_write;
            mem_valid     <= ex_valid;
            mem_rd        <= ex_rd;
            mem_reg_write <= ex_reg_write;
            if (flush || stall) begin
                ex_valid <= 1'b0;
            end else begin
                ex_valid     <= id_valid;
                ex_rn        <= id_rn;
                ex_rm        <= id_rm;
                ex_use_rn    <= id_use_rn;
                ex_use_rm    <= id_use_rm;
                ex_rd        <= id_rd;
                ex_reg_write <= id_reg_write;
                ex_mem_read  <= id_mem_read;
            end
        end
    end

    // Saturating count of cycles spent stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_count <= '0;
        end else if (stall && (stall_count != {CNT_W{1'b1}})) begin
            stall_count <= stall_count + CNT_W'(1);
        end
    end

    fwd_sel_unit #(
        .REG_ADDR_W (REG_ADDR_W),
        .ZERO_REG   (ZERO_REG)
    ) u_sel_a (
        .ex_valid      (ex_valid),
        .ex_use        (ex_use_rn),
        .ex_src        (ex_rn),
        .mem_valid     (mem_valid),
        .mem_reg_write (mem_reg_write),
        .mem_rd        (mem_rd),
        .wb_valid      (wb_valid),
        .wb_reg_write  (wb_reg_write),
        .wb_rd         (wb_rd),
        .sel           (fwd_a_sel)
    );

    fwd_sel_unit #(
        .REG_ADDR_W (REG_ADDR_W),
        .ZERO_REG   (ZERO_REG)
    ) u_sel_b (
        .ex_valid      (ex_valid),
        .ex_use        (ex_use_rm),
        .ex_src        (ex_rm),
        .mem_valid     (mem_valid),
        .mem_reg_write (mem_reg_write),
        .mem_rd        (mem_rd),
        .wb_valid      (wb_valid),
        .wb_reg_write  (wb_reg_write),
        .wb_rd         (wb_rd),
        .sel           (fwd_b_sel)
    );

endmodule
